// File: rtl/jtcontra_prom_we.sv
// jtcontra_prom_we
//   Download router between the loader and the SDRAM controller / video PROMs.
//   The address of each incoming byte selects one of four SDRAM banks or the colour
//   PROM area. SDRAM writes use a request/ack handshake and can buffer one extra byte.
//   PROM writes become a single-cycle strobe that does not depend on the SDRAM path.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   downloading                     loader active
//   ioctl_addr/ioctl_data/ioctl_wr  incoming byte and its one-cycle strobe
//   prog_addr/data/mask/ba/we       SDRAM write request, held until sdram_ack
//   sdram_ack                       controller accepted the current request
//   prom_addr/prom_data/prom_we     PROM nibble write
//   dwnld_busy                      download or SDRAM work still pending
//   overflow                        sticky flag: an SDRAM byte was dropped
module jtcontra_prom_we #(
    parameter logic [24:0] BA1_START  = 25'h04_0000,
    parameter logic [24:0] BA2_START  = 25'h05_0000,
    parameter logic [24:0] BA3_START  = 25'h09_0000,
    parameter logic [24:0] PROM_START = 25'h0D_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        sdram_ack,
    output logic [9:0]  prom_addr,
    output logic [3:0]  prom_data,
    output logic        prom_we,
    output logic        dwnld_busy,
    output logic        overflow
);

    localparam logic [24:0] PROM_END = PROM_START + 25'd1024;

    typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

    state_e      state_q;
    logic [21:0] prog_addr_q;
    logic [7:0]  prog_data_q;
    logic [1:0]  prog_mask_q;
    logic [1:0]  prog_ba_q;
    logic        prog_we_q;
    logic [9:0]  prom_addr_q;
    logic [3:0]  prom_data_q;
    logic        prom_we_q;
    logic        overflow_q;
    logic        dl_q;
    // Skid buffer
    logic        buf_q;
    logic [21:0] buf_addr_q;
    logic [7:0]  buf_data_q;
    logic [1:0]  buf_mask_q;
    logic [1:0]  buf_ba_q;

    // Address decode; only the low 23 bits of the bank offset can be non-zero
    logic [22:0] dec_off;
    logic [1:0]  dec_ba;
    logic [9:0]  dec_idx;
    logic        is_sd;
    logic        is_prom;

    always_comb begin
        dec_off = '0;
        dec_ba  = 2'd0;
        dec_idx = ioctl_addr[9:0] - PROM_START[9:0];
        is_sd   = 1'b0;
        is_prom = 1'b0;
        if (ioctl_addr < BA1_START) begin
            is_sd   = 1'b1;
            dec_off = ioctl_addr[22:0];
        end else if (ioctl_addr < BA2_START) begin
            is_sd   = 1'b1;
            dec_ba  = 2'd1;
            dec_off = ioctl_addr[22:0] - BA1_START[22:0];
        end else if (ioctl_addr < BA3_START) begin
            is_sd   = 1'b1;
            dec_ba  = 2'd2;
            dec_off = ioctl_addr[22:0] - BA2_START[22:0];
        end else if (ioctl_addr < PROM_START) begin
            is_sd   = 1'b1;
            dec_ba  = 2'd3;
            dec_off = ioctl_addr[22:0] - BA3_START[22:0];
        end else if (ioctl_addr < PROM_END) begin
            is_prom = 1'b1;
        end
    end

    logic       sd_wr;
    logic [1:0] new_mask;
    logic       store;
    logic       drop;

    assign sd_wr    = ioctl_wr & is_sd;
    assign new_mask = dec_off[0] ? 2'b01 : 2'b10;
    // A byte that cannot be issued directly goes to the buffer; a second one is lost
    assign store    = sd_wr & ~buf_q & (state_q != StIdle);
    assign drop     = sd_wr & buf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= '0;
            prog_ba_q   <= '0;
            prog_we_q   <= 1'b0;
            prom_addr_q <= '0;
            prom_data_q <= '0;
            prom_we_q   <= 1'b0;
            overflow_q  <= 1'b0;
            dl_q        <= 1'b0;
            buf_q       <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_mask_q  <= '0;
            buf_ba_q    <= '0;
        end else begin
            dl_q      <= downloading;
            prom_we_q <= ioctl_wr & is_prom;
            if (ioctl_wr && is_prom) begin
                prom_addr_q <= dec_idx;
                prom_data_q <= ioctl_data[3:0];
            end

            if (downloading && !dl_q) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (buf_q) begin
                        prog_addr_q <= buf_addr_q;
                        prog_data_q <= buf_data_q;
                        prog_mask_q <= buf_mask_q;
                        prog_ba_q   <= buf_ba_q;
                        prog_we_q   <= 1'b1;
                        buf_q       <= 1'b0;
                        state_q     <= StWait;
                    end else if (sd_wr) begin
                        prog_addr_q <= dec_off[22:1];
                        prog_data_q <= ioctl_data;
                        prog_mask_q <= new_mask;
                        prog_ba_q   <= dec_ba;
                        prog_we_q   <= 1'b1;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (sdram_ack) begin
                        prog_we_q <= 1'b0;
                        state_q   <= StGap;
                    end
                end
                StGap: begin
                    if (buf_q) begin
                        prog_addr_q <= buf_addr_q;
                        prog_data_q <= buf_data_q;
                        prog_mask_q <= buf_mask_q;
                        prog_ba_q   <= buf_ba_q;
                        prog_we_q   <= 1'b1;
                        buf_q       <= 1'b0;
                        state_q     <= StWait;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // store only happens with the buffer empty, so it never races the clears above
            if (store) begin
                buf_q      <= 1'b1;
                buf_addr_q <= dec_off[22:1];
                buf_data_q <= ioctl_data;
                buf_mask_q <= new_mask;
                buf_ba_q   <= dec_ba;
            end
        end
    end

    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prog_ba    = prog_ba_q;
    assign prog_we    = prog_we_q;
    assign prom_addr  = prom_addr_q;
    assign prom_data  = prom_data_q;
    assign prom_we    = prom_we_q;
    assign overflow   = overflow_q;
    assign dwnld_busy = downloading | (state_q != StIdle) | buf_q | prom_we_q;

endmodule
